// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, decode handoff and branch redirect.
// id_illegal exists only when IF_OPC_CHECK_EN is defined.
interface instr_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [6:0]      id_opc;
    logic [XLEN-1:0] id_pc;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
`ifdef IF_OPC_CHECK_EN
    logic            id_illegal;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_valid, id_instr, id_opc, id_pc,
`ifdef IF_OPC_CHECK_EN
        output id_illegal,
`endif
        input  id_ready, br_taken, br_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_instr, id_opc, id_pc,
`ifdef IF_OPC_CHECK_EN
        input  id_illegal,
`endif
        output id_ready, br_taken, br_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time and hands it to decode.
// Optional opcode legality flag (id_illegal) is built when IF_OPC_CHECK_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// A valid source holds its payload stable until that edge; ready never depends on valid
// from the same side. imem_rsp_valid has no ready: memory returns exactly one response
// per accepted request, in order.
module instr_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;

`ifdef IF_OPC_CHECK_EN
    logic illegal_q, illegal_d;

    function automatic logic opc_illegal(input logic [6:0] opc);
        case (opc)
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: opc_illegal = 1'b0;
            default:                                        opc_illegal = 1'b1;
        endcase
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
`ifdef IF_OPC_CHECK_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                    if (bus.br_taken) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    // A redirect landing with the response makes it stale; no later response is owed.
                    if (drop_q || bus.br_taken) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d = bus.imem_rsp_data;
                        id_pc_d = pc_q;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = ST_HOLD;
`ifdef IF_OPC_CHECK_EN
                        illegal_d = opc_illegal(bus.imem_rsp_data[6:0]);
`endif
                    end
                end else if (bus.br_taken) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.br_taken || bus.id_ready) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (bus.br_taken) pc_d = {bus.br_target[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            instr_q <= '0;
            id_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
        end
    end

`ifdef IF_OPC_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= illegal_d;
    end
    assign bus.id_illegal = illegal_q;
`endif

    assign bus.imem_req_valid = (state_q == ST_REQ) && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = (state_q == ST_HOLD);
    assign bus.id_instr       = instr_q;
    assign bus.id_opc         = instr_q[6:0];
    assign bus.id_pc          = id_pc_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, decode stall, redirects in each state, PC wrap, reset.
// Inputs change and outputs are sampled at the falling edge.
module tb_instr_fetch;
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;
  int n_cmp;
  int n_err;

  instr_fetch_if #(.XLEN(64)) ifc ();
  instr_fetch_if #(.XLEN(64)) ifc2 ();

  instr_fetch #(.XLEN(64), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .rst(rst), .bus(ifc.master), .dbg_state(dbg_state)
  );

  instr_fetch #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .bus(ifc2.master), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, got running required finished");
    $fatal(1);
  end

  // one full REQ/WAIT/HOLD pass, returns in the HOLD cycle with id_ready=1
  task automatic fetch1(input logic [63:0] addr, input logic [31:0] data, input string tag);
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL %s req_valid got %b req 1", tag, ifc.imem_req_valid); end
    n_cmp++; if (ifc.imem_req_addr !== addr) begin n_err++; $display("FAIL %s req_addr got %h req %h", tag, ifc.imem_req_addr, addr); end
    ifc.imem_req_ready = 1'b1;
    ifc.id_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_valid !== 1'b0 || ifc.id_valid !== 1'b0) begin n_err++; $display("FAIL %s wait req/id valid got %b%b req 00", tag, ifc.imem_req_valid, ifc.id_valid); end
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data = data;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    n_cmp++; if (ifc.id_valid !== 1'b1) begin n_err++; $display("FAIL %s id_valid got %b req 1", tag, ifc.id_valid); end
    n_cmp++; if (ifc.id_pc !== addr) begin n_err++; $display("FAIL %s id_pc got %h req %h", tag, ifc.id_pc, addr); end
    n_cmp++; if (ifc.id_instr !== data) begin n_err++; $display("FAIL %s id_instr got %h req %h", tag, ifc.id_instr, data); end
    n_cmp++; if (ifc.id_opc !== data[6:0]) begin n_err++; $display("FAIL %s id_opc got %b req %b", tag, ifc.id_opc, data[6:0]); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.imem_req_ready = 0; ifc.imem_rsp_valid = 0; ifc.imem_rsp_data = '0;
    ifc.id_ready = 0; ifc.br_taken = 0; ifc.br_target = '0;
    ifc2.imem_req_ready = 0; ifc2.imem_rsp_valid = 0; ifc2.imem_rsp_data = '0;
    ifc2.id_ready = 0; ifc2.br_taken = 0; ifc2.br_target = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ifc.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset req_valid got %b req 0", ifc.imem_req_valid); end
    n_cmp++; if (ifc.id_valid !== 1'b0) begin n_err++; $display("FAIL reset id_valid got %b req 0", ifc.id_valid); end
    n_cmp++; if (ifc.id_instr !== 32'h0 || ifc.id_pc !== 64'h0) begin n_err++; $display("FAIL reset id_instr/id_pc got %h/%h req 0/0", ifc.id_instr, ifc.id_pc); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset state got %0d req 0", dbg_state); end
`ifdef IF_OPC_CHECK_EN
    n_cmp++; if (ifc.id_illegal !== 1'b0) begin n_err++; $display("FAIL reset id_illegal got %b req 0", ifc.id_illegal); end
`endif
    rst = 1'b0;
    #1;
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL first_req got %b/%h req 1/0", ifc.imem_req_valid, ifc.imem_req_addr); end
    n_cmp++; if (ifc2.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL reset_pc_wrap got %h req fffffffffffffffc", ifc2.imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [63:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 64'(i * 4);
      fetch1(a, 32'h0000_0033, "stream");
    end
  endtask

  task automatic test_hold_stall();
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_addr !== 64'hC) begin n_err++; $display("FAIL stall req_addr got %h req c", ifc.imem_req_addr); end
    ifc.imem_req_ready = 1; ifc.id_ready = 0;
    @(negedge clk);
    ifc.imem_req_ready = 0; ifc.imem_rsp_valid = 1; ifc.imem_rsp_data = 32'h00A0_2003;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifc.imem_rsp_valid = 0;
      n_cmp++; if (ifc.id_valid !== 1'b1 || ifc.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall valids cyc %0d got id %b req %b req 1/0", i, ifc.id_valid, ifc.imem_req_valid); end
      n_cmp++; if (ifc.id_instr !== 32'h00A0_2003 || ifc.id_pc !== 64'hC) begin n_err++; $display("FAIL stall payload cyc %0d got %h/%h req 00a02003/c", i, ifc.id_instr, ifc.id_pc); end
    end
    ifc.id_ready = 1;
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h10) begin n_err++; $display("FAIL stall release got %b/%h req 1/10", ifc.imem_req_valid, ifc.imem_req_addr); end
  endtask

  task automatic test_branch_wait();
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_addr !== 64'h10) begin n_err++; $display("FAIL br_wait addr got %h req 10", ifc.imem_req_addr); end
    ifc.imem_req_ready = 1;
    @(negedge clk);
    ifc.imem_req_ready = 0; ifc.br_taken = 1; ifc.br_target = 64'h107;
    @(negedge clk);
    ifc.br_taken = 0; ifc.imem_rsp_valid = 1; ifc.imem_rsp_data = 32'h0000_0033;
    n_cmp++; if (ifc.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL br_wait still_wait got %b req 0", ifc.imem_req_valid); end
    @(negedge clk);
    ifc.imem_rsp_valid = 0;
    n_cmp++; if (ifc.id_valid !== 1'b0) begin n_err++; $display("FAIL br_wait dropped got id_valid %b req 0", ifc.id_valid); end
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h104) begin n_err++; $display("FAIL br_wait target got %b/%h req 1/104", ifc.imem_req_valid, ifc.imem_req_addr); end
    fetch1(64'h104, 32'h00B5_2023, "br_wait_next");
  endtask

  task automatic test_branch_hold();
    @(negedge clk);
    n_cmp++; if (ifc.imem_req_addr !== 64'h108) begin n_err++; $display("FAIL br_hold addr got %h req 108", ifc.imem_req_addr); end
    ifc.imem_req_ready = 1;
    @(negedge clk);
    ifc.imem_req_ready = 0; ifc.imem_rsp_valid = 1; ifc.imem_rsp_data = 32'h0000_0033;
    @(negedge clk);
    ifc.imem_rsp_valid = 0;
    n_cmp++; if (ifc.id_valid !== 1'b1 || ifc.id_pc !== 64'h108) begin n_err++; $display("FAIL br_hold held got %b/%h req 1/108", ifc.id_valid, ifc.id_pc); end
    ifc.br_taken = 1; ifc.br_target = 64'h200; ifc.id_ready = 1;
    @(negedge clk);
    ifc.br_taken = 0;
    n_cmp++; if (ifc.id_valid !== 1'b0) begin n_err++; $display("FAIL br_hold flush got %b req 0", ifc.id_valid); end
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h200) begin n_err++; $display("FAIL br_hold target got %b/%h req 1/200", ifc.imem_req_valid, ifc.imem_req_addr); end
  endtask

  task automatic test_branch_req();
    ifc.br_taken = 1; ifc.br_target = 64'h303;
    @(negedge clk);
    ifc.br_taken = 0;
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h300) begin n_err++; $display("FAIL br_req_nohs got %b/%h req 1/300", ifc.imem_req_valid, ifc.imem_req_addr); end
    ifc.imem_req_ready = 1; ifc.br_taken = 1; ifc.br_target = 64'h400;
    @(negedge clk);
    ifc.imem_req_ready = 0; ifc.br_taken = 0;
    n_cmp++; if (ifc.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL br_req_hs wait got %b req 0", ifc.imem_req_valid); end
    ifc.imem_rsp_valid = 1; ifc.imem_rsp_data = 32'h0000_0033;
    @(negedge clk);
    ifc.imem_rsp_valid = 0;
    n_cmp++; if (ifc.id_valid !== 1'b0 || ifc.imem_req_addr !== 64'h400) begin n_err++; $display("FAIL br_req_hs drop got %b/%h req 0/400", ifc.id_valid, ifc.imem_req_addr); end
    ifc.imem_req_ready = 1;
    @(negedge clk);
    ifc.imem_req_ready = 0; ifc.imem_rsp_valid = 1; ifc.br_taken = 1; ifc.br_target = 64'h500;
    @(negedge clk);
    ifc.imem_rsp_valid = 0; ifc.br_taken = 0;
    n_cmp++; if (ifc.id_valid !== 1'b0 || ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h500) begin n_err++; $display("FAIL br_wait_same got %b/%b/%h req 0/1/500", ifc.id_valid, ifc.imem_req_valid, ifc.imem_req_addr); end
    fetch1(64'h500, 32'h0000_0063, "br_after_coincident");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    n_cmp++; if (ifc2.imem_req_valid !== 1'b1 || ifc2.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap first got %b/%h req 1/fffffffffffffffc", ifc2.imem_req_valid, ifc2.imem_req_addr); end
    ifc2.imem_req_ready = 1; ifc2.id_ready = 1;
    @(negedge clk);
    ifc2.imem_req_ready = 0; ifc2.imem_rsp_valid = 1; ifc2.imem_rsp_data = 32'h0000_0033;
    @(negedge clk);
    ifc2.imem_rsp_valid = 0;
    n_cmp++; if (ifc2.id_valid !== 1'b1 || ifc2.id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap held got %b/%h req 1/fffffffffffffffc", ifc2.id_valid, ifc2.id_pc); end
    @(negedge clk);
    n_cmp++; if (ifc2.imem_req_valid !== 1'b1 || ifc2.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL wrap second got %b/%h req 1/0", ifc2.imem_req_valid, ifc2.imem_req_addr); end
  endtask

`ifdef IF_OPC_CHECK_EN
  task automatic test_opc_check();
    fetch1(64'h504, 32'h0000_0013, "opc_addi");
    n_cmp++; if (ifc.id_illegal !== 1'b1) begin n_err++; $display("FAIL opc_addi illegal got %b req 1", ifc.id_illegal); end
    fetch1(64'h508, 32'h0000_0063, "opc_branch");
    n_cmp++; if (ifc.id_illegal !== 1'b0) begin n_err++; $display("FAIL opc_branch illegal got %b req 0", ifc.id_illegal); end
  endtask
`endif

  task automatic test_mid_reset();
    @(negedge clk);
    ifc.imem_req_ready = 1;
    @(negedge clk);
    ifc.imem_req_ready = 0;
    rst = 1;
    #1;
    n_cmp++; if (ifc.imem_req_valid !== 1'b0 || ifc.id_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset outputs got %b/%b req 0/0", ifc.imem_req_valid, ifc.id_valid); end
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++; if (ifc.imem_req_valid !== 1'b1 || ifc.imem_req_addr !== 64'h0 || ifc.id_pc !== 64'h0) begin n_err++; $display("FAIL mid_reset restart got %b/%h/%h req 1/0/0", ifc.imem_req_valid, ifc.imem_req_addr, ifc.id_pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_hold_stall();
    test_branch_wait();
    test_branch_hold();
    test_branch_req();
    test_wrap();
`ifdef IF_OPC_CHECK_EN
    test_opc_check();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
